seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_det_core.sv | 55 +++++
 rtl/seq_detect_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the "1101" sequence detector and its scan controller.
// Holds the controller state encoding, the detector state encoding and the
// pattern constant that the detector matches.
package seq_det_pkg;

  // Pattern to detect; bit 3 is the first bit seen in the serial stream.
  localparam logic [3:0] PATTERN = 4'b1101;

  // Scan controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  // Detector states: Sn means the last n bits matched the pattern prefix.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

endpackage

// File: rtl/seq_det_core.sv
// Overlapping Mealy detector for the serial pattern in seq_det_pkg::PATTERN.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (state S0, y low)
//   clr  - synchronous clear to S0 (y low the following cycle)
//   x    - serial input bit, sampled every edge
//   y    - registered hit: high the cycle after the edge that saw the last
//          pattern bit
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic x,
  output logic y
);

  det_state_t state_q;
  det_state_t state_n;
  logic       y_n;

  // State and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
      y       <= 1'b0;
    end else begin
      state_q <= state_n;
      y       <= y_n;
    end
  end

  // Next state and hit. The fallback targets on a mismatch are specific to
  // 1101: a failing '1' after "1101" or "11" still leaves a usable prefix.
  always_comb begin
    state_n = state_q;
    y_n     = 1'b0;
    if (clr) begin
      state_n = S0;
    end else begin
      case (state_q)
        S0: state_n = (x == PATTERN[3]) ? S1 : S0;
        S1: state_n = (x == PATTERN[2]) ? S2 : S0;
        S2: state_n = (x == PATTERN[1]) ? S3 : S2;
        S3: begin
          state_n = (x == PATTERN[0]) ? S1 : S0;
          y_n     = (x == PATTERN[0]);
        end
        default: state_n = S0;
      endcase
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame scan controller: loads a frame, shifts it MSB first through the
// 1101 detector, counts (overlapping) matches and records the scan index of
// the first match's final bit.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - scan request, accepted only in IDLE (abort wins)
//   abort        - cancel an in-progress scan, no done pulse
//   frame_in     - frame to scan, bit FRAME_W-1 scanned first
//   busy         - scan in progress (SHIFT and DRAIN)
//   done         - one-cycle pulse when results are final
//   match_count  - saturating match count of the last scan
//   first_pos    - index of the first match's final bit, all-ones if none
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] frame_in,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic [CNT_W-1:0]   first_pos
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

  ctrl_state_t        state_q;
  ctrl_state_t        state_n;
  logic               busy_n;
  logic               done_n;
  logic               load;
  logic               shift;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   idx;
  logic               det_x;
  logic               det_y;
  logic               hit;

  // Detector sees frame bits only while shifting; zeros otherwise.
  assign det_x = (state_q == SHIFT) && shreg[FRAME_W-1];

  // A registered hit only belongs to the scan while it is still running.
  assign hit = det_y && (state_q != IDLE);

  seq_det_core u_core (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .x   (det_x),
    .y   (det_y)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Controller next state and datapath strobes.
  always_comb begin
    state_n = state_q;
    done_n  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          shift = 1'b1;
          if (idx == LAST_IDX) state_n = DRAIN;
        end
      end
      DRAIN: begin
        state_n = IDLE;
        done_n  = !abort;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Shift register, bit index, result registers and status outputs.
  // idx runs one ahead of the bit whose hit is currently visible on det_y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      idx         <= '0;
      match_count <= '0;
      first_pos   <= CNT_MAX;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy <= busy_n;
      done <= done_n;
      if (load) begin
        shreg       <= frame_in;
        idx         <= '0;
        match_count <= '0;
        first_pos   <= CNT_MAX;
      end else begin
        if (shift) begin
          shreg <= {shreg[FRAME_W-2:0], 1'b0};
          idx   <= idx + CNT_W'(1);
        end
        if (hit) begin
          if (match_count != CNT_MAX) match_count <= match_count + CNT_W'(1);
          if (first_pos == CNT_MAX)   first_pos   <= idx - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed testbench for seq_detect_ctrl (FRAME_W=16, CNT_W=5).
module tb_seq_detect_ctrl;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_W   = 5;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [FRAME_W-1:0] frame_in;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   match_count;
  logic [CNT_W-1:0]   first_pos;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [FRAME_W-1:0] frame;
    int                 cnt;
    int                 pos;
  } vec_t;

  vec_t vecs[7];

  seq_detect_ctrl #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .frame_in    (frame_in),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .first_pos   (first_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Counts edges from the current negedge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  // Watches a number of cycles and reports whether done ever pulsed.
  task automatic no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(name, seen, 0);
  endtask

  // Requests a scan; returns at the negedge after E0 with start released.
  task automatic issue(input logic [FRAME_W-1:0] f);
    @(negedge clk);
    start    = 1'b1;
    frame_in = f;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_scan(input string name, input logic [FRAME_W-1:0] f,
                         input int exp_cnt, input int exp_pos);
    int n;
    issue(f);
    chk({name, " busy"}, int'(busy), 1);
    wait_done(n);
    chk({name, " latency"}, n, 17);
    chk({name, " busy_at_done"}, int'(busy), 0);
    chk({name, " count"}, int'(match_count), exp_cnt);
    chk({name, " first_pos"}, int'(first_pos), exp_pos);
    @(negedge clk);
    chk({name, " done_width"}, int'(done), 0);
    chk({name, " count_hold"}, int'(match_count), exp_cnt);
  endtask

  initial begin
    int n;

    vecs[0] = '{16'hD000, 1, 3};
    vecs[1] = '{16'hDDDD, 4, 3};
    vecs[2] = '{16'hF400, 1, 5};
    vecs[3] = '{16'hDB00, 2, 3};
    vecs[4] = '{16'hFFFF, 0, 31};
    vecs[5] = '{16'h0000, 0, 31};
    vecs[6] = '{16'hB6DB, 4, 5};

    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    frame_in = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset count", int'(match_count), 0);
    chk("reset first_pos", int'(first_pos), 31);
    rst = 1'b0;

    // Abort in IDLE does nothing.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort busy", int'(busy), 0);
    chk("idle abort done", int'(done), 0);

    foreach (vecs[i]) do_scan($sformatf("vec%0d", i), vecs[i].frame, vecs[i].cnt, vecs[i].pos);

    // Abort at E5: no done, idle next cycle, then a clean rescan.
    issue(16'hDDDD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    no_done("abort no_done", 20);
    do_scan("after_abort", 16'hD000, 1, 3);

    // Reset mid-scan around E8: scan discarded, no done after release.
    issue(16'hDDDD);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst count", int'(match_count), 0);
    chk("rst first_pos", int'(first_pos), 31);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy after", int'(busy), 0);
    no_done("rst no_done", 20);
    do_scan("after_rst", 16'hD000, 1, 3);

    // Start pulsed at E3 while busy is ignored.
    issue(16'hD000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    frame_in = 16'hDDDD;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    wait_done(n);
    chk("busy_start latency", n + 3, 17);
    chk("busy_start count", int'(match_count), 1);
    chk("busy_start first_pos", int'(first_pos), 3);

    // Back-to-back: start on the done cycle is accepted.
    issue(16'hD000);
    wait_done(n);
    chk("b2b first latency", n, 17);
    chk("b2b first count", int'(match_count), 1);
    start    = 1'b1;
    frame_in = 16'hDDDD;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", int'(busy), 1);
    chk("b2b cleared count", int'(match_count), 0);
    wait_done(n);
    chk("b2b second latency", n, 17);
    chk("b2b second count", int'(match_count), 4);
    chk("b2b second first_pos", int'(first_pos), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
